// File: rtl/hazard_stall_unit.sv
// Load-use, dmem-wait and redirect hazard control for the 5-stage RV32I pipe.
// Ports: ID/EX hazard inputs, MEM req/ready in; stall/bubble/flush, timeout, stall count out.
module hazard_stall_unit #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [2:0]       ID_ValidReg,
  input  logic [4:0]       EX_rd,
  input  logic [2:0]       EX_ValidReg,
  input  logic             EX_MemRead,
  input  logic             EX_redirect,
  input  logic             MEM_mem_req,
  input  logic             MEM_mem_ready,
  output logic             IF_stall,
  output logic             ID_stall,
  output logic             EX_bubble,
  output logic             EX_stall,
  output logic             WB_bubble,
  output logic             ID_flush,
  output logic             EX_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam logic [WAIT_W-1:0] MAXW = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] ONE  = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pend_q, pend_d;
  logic              to_q, to_d;
  logic [CNT_W-1:0]  cnt_q;

  logic lu;
  logic mw;

  assign lu = EX_MemRead & EX_ValidReg[0] & (EX_rd != 5'd0) &
              ((ID_ValidReg[1] & (ID_rs1 == EX_rd)) |
               (ID_ValidReg[2] & (ID_rs2 == EX_rd)));
  assign mw = MEM_mem_req & ~MEM_mem_ready;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pend_d    = pend_q;
    to_d      = to_q;
    IF_stall  = 1'b0;
    ID_stall  = 1'b0;
    EX_bubble = 1'b0;
    EX_stall  = 1'b0;
    WB_bubble = 1'b0;
    ID_flush  = 1'b0;
    EX_flush  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mw) begin
          IF_stall  = 1'b1;
          ID_stall  = 1'b1;
          EX_stall  = 1'b1;
          WB_bubble = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = ONE;
          if (ONE == MAXW) to_d = 1'b1;
          // redirect is parked until the access completes
          if (EX_redirect) pend_d = 1'b1;
        end else if (EX_redirect) begin
          ID_flush = 1'b1;
          EX_flush = 1'b1;
        end else if (lu) begin
          IF_stall  = 1'b1;
          ID_stall  = 1'b1;
          EX_bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!MEM_mem_ready) begin
          IF_stall  = 1'b1;
          ID_stall  = 1'b1;
          EX_stall  = 1'b1;
          WB_bubble = 1'b1;
          if (wait_q != MAXW) wait_d = wait_q + ONE;
          if (wait_d == MAXW) to_d = 1'b1;
          if (EX_redirect) pend_d = 1'b1;
        end else begin
          state_d = RUN;
          wait_d  = '0;
          pend_d  = 1'b0;
          if (pend_q | EX_redirect) begin
            ID_flush = 1'b1;
            EX_flush = 1'b1;
          end else if (lu) begin
            IF_stall  = 1'b1;
            ID_stall  = 1'b1;
            EX_bubble = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      pend_q  <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
      cnt_q   <= cnt_q + CNT_W'(IF_stall);
    end
  end

  assign mem_timeout  = to_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed vector bench for hazard_stall_unit.
// Table of single-cycle RUN vectors plus multi-cycle wait/redirect/reset sequences.
module tb_hazard_stall_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic [2:0]  ID_ValidReg, EX_ValidReg;
  logic        EX_MemRead, EX_redirect;
  logic        MEM_mem_req, MEM_mem_ready;
  logic        IF_stall, ID_stall, EX_bubble, EX_stall;
  logic        WB_bubble, ID_flush, EX_flush, mem_timeout;
  logic [31:0] stall_cycles;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_ValidReg(ID_ValidReg),
    .EX_rd(EX_rd), .EX_ValidReg(EX_ValidReg),
    .EX_MemRead(EX_MemRead), .EX_redirect(EX_redirect),
    .MEM_mem_req(MEM_mem_req), .MEM_mem_ready(MEM_mem_ready),
    .IF_stall(IF_stall), .ID_stall(ID_stall), .EX_bubble(EX_bubble),
    .EX_stall(EX_stall), .WB_bubble(WB_bubble),
    .ID_flush(ID_flush), .EX_flush(EX_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {IF_stall,ID_stall,EX_bubble,EX_stall,WB_bubble,ID_flush,EX_flush}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1110000;
  localparam logic [6:0] MW   = 7'b1101100;
  localparam logic [6:0] FL   = 7'b0000011;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] idv;
    logic [4:0] exrd;
    logic [2:0] exv;
    logic       mr;
    logic       redir;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  int   tests  = 0;
  int   fails  = 0;
  int   exp_cnt = 0;
  logic exp_to = 1'b0;
  vec_t tbl[10];

  function automatic vec_t mk(
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] idv,
    input logic [4:0] exrd, input logic [2:0] exv, input logic mr,
    input logic redir, input logic req, input logic rdy,
    input logic [6:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.idv = idv; v.exrd = exrd; v.exv = exv;
    v.mr = mr; v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] ctrl();
    return {IF_stall, ID_stall, EX_bubble, EX_stall,
            WB_bubble, ID_flush, EX_flush};
  endfunction

  task automatic drive(input vec_t v);
    ID_rs1 = v.rs1; ID_rs2 = v.rs2; ID_ValidReg = v.idv;
    EX_rd = v.exrd; EX_ValidReg = v.exv; EX_MemRead = v.mr;
    EX_redirect = v.redir; MEM_mem_req = v.req; MEM_mem_ready = v.rdy;
  endtask

  task automatic step(input string name, input vec_t v);
    @(posedge clk);
    #1 drive(v);
    @(negedge clk);
    tests++;
    if (ctrl() !== v.exp) begin
      fails++;
      $display("FAIL %s ctrl: got %b want %b", name, ctrl(), v.exp);
    end
    tests++;
    if (mem_timeout !== exp_to) begin
      fails++;
      $display("FAIL %s timeout: got %b want %b", name, mem_timeout, exp_to);
    end
    tests++;
    if (stall_cycles !== 32'(exp_cnt)) begin
      fails++;
      $display("FAIL %s stall_cycles: got %0d want %0d",
               name, stall_cycles, exp_cnt);
    end
    if (v.exp[6]) exp_cnt++;
  endtask

  vec_t q, w, wr, rd;

  initial begin
    q  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE);
    rst = 1'b1;
    drive(q);
    #12;
    tests++;
    if (ctrl() !== NONE || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL reset: got %b/%b/%0d want 0", ctrl(), mem_timeout,
               stall_cycles);
    end
    @(negedge clk) rst = 1'b0;

    tbl[0] = mk(0, 0, 3'b000, 0, 3'b000, 0, 0, 0, 0, NONE);
    tbl[1] = mk(5, 0, 3'b011, 5, 3'b001, 1, 0, 0, 0, LU);
    tbl[2] = mk(0, 0, 3'b011, 0, 3'b001, 1, 0, 0, 0, NONE);
    tbl[3] = mk(3, 5, 3'b011, 5, 3'b001, 1, 0, 0, 0, NONE);
    tbl[4] = mk(3, 5, 3'b101, 5, 3'b001, 1, 0, 0, 0, LU);
    tbl[5] = mk(5, 5, 3'b111, 5, 3'b001, 0, 0, 0, 0, NONE);
    tbl[6] = mk(5, 5, 3'b111, 5, 3'b000, 1, 0, 0, 0, NONE);
    tbl[7] = mk(5, 0, 3'b011, 5, 3'b001, 1, 1, 0, 0, FL);
    tbl[8] = mk(0, 0, 3'b000, 0, 3'b000, 0, 0, 1, 1, NONE);
    tbl[9] = mk(9, 9, 3'b111, 9, 3'b001, 1, 0, 1, 1, LU);

    for (int i = 0; i < 10; i++) step($sformatf("vec%0d", i), tbl[i]);
    step("after_vec", q);

    w  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, MW);
    wr = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, MW);
    rd = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, NONE);

    // three-cycle dmem wait
    for (int i = 0; i < 3; i++) step($sformatf("wait3_%0d", i), w);
    step("wait3_ready", rd);
    step("wait3_run", q);

    // redirect arriving during a wait is held until ready
    step("pend_first", wr);
    step("pend_w1", w);
    step("pend_ready", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, FL));
    step("pend_after", q);

    // load-use still evaluated on the ready cycle
    step("lu_wait", w);
    step("lu_ready", mk(7, 0, 3'b011, 7, 3'b001, 1, 0, 1, 1, LU));
    step("lu_after", q);

    // timeout after MAX_WAIT stalled cycles
    for (int i = 1; i <= 255; i++) step($sformatf("to_%0d", i), w);
    exp_to = 1'b1;
    step("to_256", w);
    step("to_ready", rd);
    step("to_run", q);

    // reset in the middle of a wait with a redirect pending
    step("rst_first", wr);
    step("rst_w1", w);
    @(posedge clk);
    #1 drive(q);
    rst = 1'b1;
    #1;
    tests++;
    if (ctrl() !== NONE || mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset: got %b/%b/%0d want 0", ctrl(), mem_timeout,
               stall_cycles);
    end
    exp_cnt = 0;
    exp_to  = 1'b0;
    @(negedge clk) rst = 1'b0;
    step("rst_ready", rd);
    step("rst_run", q);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
